// File: rtl/btn_step_pulse_if.sv
// Button step-pulse interface: debounced button level in, step strobe,
// held flag and wrapping pulse count out.
interface btn_step_pulse_if #(
   parameter int CNT_W = 8
);
   logic             btn_db;
   logic             step_pulse;
   logic             held;
   logic [CNT_W-1:0] press_count;

   // Button source / display side
   modport master (
      output btn_db,
      input  step_pulse,
      input  held,
      input  press_count
   );

   // Step-pulse generator side
   modport slave (
      input  btn_db,
      output step_pulse,
      output held,
      output press_count
   );
endinterface

// File: rtl/btn_step_pulse.sv
// btn_step_pulse: turns the debounced push-button level into one-cycle step
// strobes and keeps a wrapping count of strobes for the board LEDs.
// Optional feature macro: BTN_AUTOREPEAT_EN (hold-then-repeat while pressed).
// Without it only IDLE/PRESSED are used and the timer is not built.
//
// state   | meaning
// IDLE    | button released, waiting for a rising edge
// PRESSED | first strobe issued; without auto-repeat, waits here for release
// HOLD    | held after first strobe, counting towards first repeat
// REPEAT  | auto-repeating every REPEAT_CYCLES while held
module btn_step_pulse #(
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000,
   parameter int CNT_W         = 8,
   parameter int TMR_W         = 32
) (
   input logic               clk,
   input logic               rst,
   btn_step_pulse_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, PRESSED, HOLD, REPEAT} state_t;

   if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2 || TMR_W < 2) begin : g_bad_params
      $error("btn_step_pulse: HOLD_CYCLES/REPEAT_CYCLES must be >= 2, TMR_W >= 2");
   end

   logic [1:0]       sync_q;
   logic             b_prev;
   logic [2:0]       vld_q;
   logic             b_s;
   logic             rise;
   logic             fall;
   state_t           state_q, state_d;
   logic             pulse_q, pulse_d;
   logic [CNT_W-1:0] cnt_q;
`ifdef BTN_AUTOREPEAT_EN
   logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

   // Synchroniser, edge-history register and post-reset fill tracker
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 2'b00;
         b_prev <= 1'b0;
         vld_q  <= 3'b000;
      end else begin
         sync_q <= {sync_q[0], bus.btn_db};
         b_prev <= sync_q[1];
         vld_q  <= {vld_q[1:0], 1'b1};
      end
   end

   // A level already high when reset releases is not a press: b_prev only
   // counts once it holds a real sample of the button.
   assign b_s  = sync_q[1];
   assign rise = b_s & ~b_prev & vld_q[2];
   assign fall = ~b_s;

   // Next-state and strobe decode; release always wins over a timer expiry
   always_comb begin
      state_d = state_q;
      pulse_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      tmr_d   = tmr_q;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = PRESSED;
               pulse_d = 1'b1;
               tmr_d   = '0;
            end
         end
         PRESSED: begin
            // The PRESSED cycle counts towards the hold time, so the first
            // repeat lands HOLD_CYCLES after the first strobe.
            if (fall) begin
               state_d = IDLE;
               tmr_d   = '0;
            end else begin
               state_d = HOLD;
               tmr_d   = tmr_q + TMR_W'(1);
            end
         end
         HOLD: begin
            if (fall) begin
               state_d = IDLE;
               tmr_d   = '0;
            end else if (tmr_q == TMR_W'(HOLD_CYCLES - 1)) begin
               state_d = REPEAT;
               pulse_d = 1'b1;
               tmr_d   = '0;
            end else begin
               tmr_d   = tmr_q + TMR_W'(1);
            end
         end
         REPEAT: begin
            if (fall) begin
               state_d = IDLE;
               tmr_d   = '0;
            end else if (tmr_q == TMR_W'(REPEAT_CYCLES - 1)) begin
               pulse_d = 1'b1;
               tmr_d   = '0;
            end else begin
               tmr_d   = tmr_q + TMR_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            tmr_d   = '0;
         end
      endcase
`else
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = PRESSED;
               pulse_d = 1'b1;
            end
         end
         PRESSED: begin
            if (fall) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
`endif
   end

   // State, strobe and pulse-count registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
`ifdef BTN_AUTOREPEAT_EN
         tmr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         pulse_q <= pulse_d;
         if (pulse_d) cnt_q <= cnt_q + CNT_W'(1);
`ifdef BTN_AUTOREPEAT_EN
         tmr_q   <= tmr_d;
`endif
      end
   end

   assign bus.step_pulse  = pulse_q;
   assign bus.held        = (state_q != IDLE);
   assign bus.press_count = cnt_q;

endmodule

// File: tb/tb_btn_step_pulse.sv
// Bench for btn_step_pulse with HOLD_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4.
// Step i means: btn_db applied before edge i of the sequence, outputs
// sampled 1 time unit after that edge.
module tb_btn_step_pulse;
   localparam int CNT_W = 4;
`ifdef BTN_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   exp_cnt  = 0;

   btn_step_pulse_if #(.CNT_W(CNT_W)) bus ();

   btn_step_pulse #(
      .HOLD_CYCLES  (8),
      .REPEAT_CYCLES(4),
      .CNT_W        (CNT_W),
      .TMR_W        (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic btn;
      logic pulse;
      logic held;
      int   count;
   } vec_t;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic step(input logic b);
      bus.btn_db = b;
      @(posedge clk);
      #1;
   endtask

   // Press held for h steps starting at step 0: first strobe at step 2,
   // repeats at 10, 14, 18 ... while the synchronised level is still high.
   function automatic bit exp_pulse(input int i, input int h);
      if (i == 2 && h >= 1) return 1'b1;
      if (AR && i >= 10 && ((i - 10) % 4) == 0 && i <= h + 1) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit exp_held(input int i, input int h);
      return (i >= 2 && i <= h + 1);
   endfunction

   task automatic press(input string name, input int h, input int len);
      for (int i = 0; i < len; i++) begin
         step(i < h);
         if (exp_pulse(i, h)) exp_cnt = (exp_cnt + 1) % 16;
         check({name, "_pulse"}, int'(bus.step_pulse), int'(exp_pulse(i, h)));
         check({name, "_held"},  int'(bus.held),       int'(exp_held(i, h)));
         check({name, "_count"}, int'(bus.press_count), exp_cnt);
      end
   endtask

   initial begin
      vec_t tbl[10];
      for (int i = 0; i < 10; i++) begin
         tbl[i].btn   = (i < 3);
         tbl[i].pulse = (i == 2);
         tbl[i].held  = (i >= 2 && i <= 4);
         tbl[i].count = (i >= 2) ? 1 : 0;
      end

      // Reset with the button already held
      rst        = 1'b1;
      bus.btn_db = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pulse", int'(bus.step_pulse), 0);
      check("rst_held",  int'(bus.held),       0);
      check("rst_count", int'(bus.press_count), 0);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         step(1'b1);
         check("held_at_rst_pulse", int'(bus.step_pulse), 0);
         check("held_at_rst_held",  int'(bus.held),       0);
      end
      check("held_at_rst_count", int'(bus.press_count), 0);
      repeat (4) step(1'b0);

      // Short press, table driven
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].btn);
         check("tbl_pulse", int'(bus.step_pulse),  int'(tbl[i].pulse));
         check("tbl_held",  int'(bus.held),        int'(tbl[i].held));
         check("tbl_count", int'(bus.press_count), tbl[i].count);
      end
      exp_cnt = 1;

      // Long hold: auto-repeat, or a single strobe without it
      press("hold40", 40, 46);
      // Release landing on the repeat-timer expiry cycle
      press("rel_expiry", 12, 18);

      // Count wrap over 17 presses from a fresh reset
      rst = 1'b1;
      #1;
      exp_cnt = 0;
      check("rst2_count", int'(bus.press_count), 0);
      rst = 1'b0;
      repeat (4) step(1'b0);
      for (int n = 1; n <= 17; n++) begin
         press("wrap", 3, 7);
         check("wrap_total", int'(bus.press_count), n % 16);
      end

      // Asynchronous reset in the middle of a hold
      for (int i = 0; i <= 10; i++) begin
         step(1'b1);
         if (exp_pulse(i, 100)) exp_cnt = (exp_cnt + 1) % 16;
      end
      check("pre_rst_pulse", int'(bus.step_pulse),  int'(AR));
      check("pre_rst_held",  int'(bus.held),        1);
      check("pre_rst_count", int'(bus.press_count), exp_cnt);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_pulse", int'(bus.step_pulse),  0);
      check("async_rst_held",  int'(bus.held),        0);
      check("async_rst_count", int'(bus.press_count), 0);
      bus.btn_db = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) step(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
